// File: rtl/traffic_pkg.sv
// Shared encodings for the phase scheduler: state codes and LEDS patterns.
// LEDS bit order is {NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R}.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_NS_G = 3'd0,
        ST_NS_Y = 3'd1,
        ST_AR1  = 3'd2,
        ST_EW_G = 3'd3,
        ST_EW_Y = 3'd4,
        ST_AR2  = 3'd5
    } state_t;

    localparam logic [5:0] LED_NS_G = 6'b100001;
    localparam logic [5:0] LED_NS_Y = 6'b010001;
    localparam logic [5:0] LED_AR1  = 6'b001001;
    localparam logic [5:0] LED_EW_G = 6'b001100;
    localparam logic [5:0] LED_EW_Y = 6'b001010;
    localparam logic [5:0] LED_AR2  = 6'b001001;

    // Lamp pattern for a state code; the two unused codes show all-red.
    function automatic logic [5:0] leds_of(input logic [2:0] s);
        case (s)
            3'd0:    leds_of = LED_NS_G;
            3'd1:    leds_of = LED_NS_Y;
            3'd2:    leds_of = LED_AR1;
            3'd3:    leds_of = LED_EW_G;
            3'd4:    leds_of = LED_EW_Y;
            3'd5:    leds_of = LED_AR2;
            default: leds_of = LED_AR1;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-cycle tick every TICK_DIV clocks; counter restarts from 0 on reset.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running prescaler 0..TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/phase_scheduler.sv
// Two-road traffic phase scheduler with pedestrian truncation and walk lamps.
// Optional emergency preemption is built only when EMERG_PREEMPT_EN is defined;
// otherwise emerg_req/emerg_dir are ignored and no related logic exists.
// phase reflects the state register directly; LEDS/walk are registered.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int GREEN_NS  = 10,
    parameter int GREEN_EW  = 10,
    parameter int GREEN_MIN = 4,
    parameter int YELLOW    = 3,
    parameter int ALLRED    = 2,
    parameter int WALK      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ped_req,
    input  logic       emerg_req,
    input  logic       emerg_dir,
    output logic [5:0] LEDS,
    output logic [1:0] walk,
    output logic [2:0] phase
);
    // Last tcnt value of each timed interval.
    localparam logic [5:0] T_NSG  = 6'(GREEN_NS - 1);
    localparam logic [5:0] T_EWG  = 6'(GREEN_EW - 1);
    localparam logic [5:0] T_MIN  = 6'(GREEN_MIN - 1);
    localparam logic [5:0] T_Y    = 6'(YELLOW - 1);
    localparam logic [5:0] T_AR   = 6'(ALLRED - 1);
    localparam logic [5:0] T_WALK = 6'(WALK - 1);

    state_t     state, nstate;
    logic [5:0] tcnt;
    logic       tick;
    logic [5:0] leds_d;
    logic [1:0] pend, walk_r, enter, serve_n, blk;
    logic       tgt_ns, tgt_ew, hold, force_exit;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef EMERG_PREEMPT_EN
    assign tgt_ns = emerg_req && !emerg_dir;
    assign tgt_ew = emerg_req &&  emerg_dir;
`else
    logic unused_emerg;
    assign unused_emerg = emerg_req ^ emerg_dir;
    assign tgt_ns = 1'b0;
    assign tgt_ew = 1'b0;
`endif

    // Held in the requested green; pushed out of the opposing green.
    assign hold       = (state == ST_NS_G && tgt_ns) || (state == ST_EW_G && tgt_ew);
    assign force_exit = (state == ST_NS_G && tgt_ew) || (state == ST_EW_G && tgt_ns);

    // State register and per-state tick counter (cleared on every change).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_NS_G;
            tcnt  <= '0;
        end else begin
            state <= nstate;
            if (nstate != state)   tcnt <= '0;
            else if (tick && !hold) tcnt <= tcnt + 6'd1;
        end
    end

    // Next state: greens may end early, yellow/all-red always run full length.
    always_comb begin
        nstate = state;
        case (state)
            ST_NS_G: if (tick && !hold &&
                         (tcnt == T_NSG || force_exit || (pend[0] && tcnt >= T_MIN)))
                         nstate = ST_NS_Y;
            ST_NS_Y: if (tick && tcnt == T_Y)  nstate = ST_AR1;
            ST_AR1:  if (tick && tcnt == T_AR) nstate = ST_EW_G;
            ST_EW_G: if (tick && !hold &&
                         (tcnt == T_EWG || force_exit || (pend[1] && tcnt >= T_MIN)))
                         nstate = ST_EW_Y;
            ST_EW_Y: if (tick && tcnt == T_Y)  nstate = ST_AR2;
            ST_AR2:  if (tick && tcnt == T_AR) nstate = ST_NS_G;
            default: nstate = ST_NS_G;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        leds_d = leds_of(state);
    end

    // Lamp register: one cycle behind the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) LEDS <= LED_NS_G;
        else        LEDS <= leds_d;
    end

    // Lane 0 crosses NS and is served by EW_G; lane 1 the reverse.
    assign enter[0]   = (nstate == ST_EW_G) && (state != ST_EW_G);
    assign enter[1]   = (nstate == ST_NS_G) && (state != ST_NS_G);
    assign serve_n[0] = (nstate == ST_EW_G);
    assign serve_n[1] = (nstate == ST_NS_G);
    assign blk[0]     = tgt_ew;
    assign blk[1]     = tgt_ns;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic       ped_q, pend_q, walk_q;
        logic [5:0] wcnt;

        // Press latch and walk timer; entry to the serving green clears the latch.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ped_q  <= 1'b0;
                pend_q <= 1'b0;
                walk_q <= 1'b0;
                wcnt   <= '0;
            end else begin
                ped_q <= ped_req[i];
                if (enter[i])
                    pend_q <= 1'b0;
                else if (ped_req[i] && !ped_q && !walk_q)
                    pend_q <= 1'b1;

                if (enter[i]) begin
                    walk_q <= pend_q && !blk[i];
                    wcnt   <= '0;
                end else if (!serve_n[i] || blk[i]) begin
                    walk_q <= 1'b0;
                end else if (walk_q && tick) begin
                    if (wcnt == T_WALK) walk_q <= 1'b0;
                    else                wcnt   <= wcnt + 6'd1;
                end
            end
        end

        assign pend[i]   = pend_q;
        assign walk_r[i] = walk_q;
    end

    assign walk  = walk_r;
    assign phase = state;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler at TICK_DIV=4, greens 6, GREEN_MIN 2,
// YELLOW 3, ALLRED 2, WALK 2. Expected durations are in clock cycles.
module tb_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ped_req = 2'b00;
    logic       emerg_req = 1'b0;
    logic       emerg_dir = 1'b0;
    logic [5:0] LEDS;
    logic [1:0] walk;
    logic [2:0] phase;

    int checks = 0;
    int failures = 0;

    localparam logic [5:0] L_NSG = 6'b100001;
    localparam logic [5:0] L_NSY = 6'b010001;
    localparam logic [5:0] L_AR  = 6'b001001;
    localparam logic [5:0] L_EWG = 6'b001100;
    localparam logic [5:0] L_EWY = 6'b001010;

    phase_scheduler #(
        .TICK_DIV(4), .GREEN_NS(6), .GREEN_EW(6), .GREEN_MIN(2),
        .YELLOW(3), .ALLRED(2), .WALK(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ped_req   (ped_req),
        .emerg_req (emerg_req),
        .emerg_dir (emerg_dir),
        .LEDS      (LEDS),
        .walk      (walk),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks the current phase, stays in it counting cycles (bounded), and
    // checks length, lamp pattern and walk-lamp cycles seen in that phase.
    task automatic step(input string tag, input int ph, input int len,
                        input logic [5:0] led, input int w0, input int w1);
        int n, c0, c1;
        logic [5:0] l;
        n = 0; c0 = 0; c1 = 0; l = '0;
        chk({tag, "_phase"}, int'(phase), ph);
        while (phase == 3'(ph) && n < 500) begin
            if (n == 1) l = LEDS;
            c0 += int'(walk[0]);
            c1 += int'(walk[1]);
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"},   n, len);
        chk({tag, "_leds"},  int'(l), int'(led));
        chk({tag, "_walk0"}, c0, w0);
        chk({tag, "_walk1"}, c1, w1);
    endtask

    task automatic pulse(input logic [1:0] v);
        ped_req = v;
        @(negedge clk);
        ped_req = 2'b00;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_leds",  int'(LEDS),  int'(L_NSG));
        chk("rst_walk",  int'(walk),  0);
        chk("rst_phase", int'(phase), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run, no inputs
        step("fr_nsg", 0, 24, L_NSG, 0, 0);
        step("fr_nsy", 1, 12, L_NSY, 0, 0);
        step("fr_ar1", 2,  8, L_AR,  0, 0);
        step("fr_ewg", 3, 24, L_EWG, 0, 0);
        step("fr_ewy", 4, 12, L_EWY, 0, 0);
        step("fr_ar2", 5,  8, L_AR,  0, 0);

        // NS-road crossing press at start of NS_G: NS_G truncated to 2 ticks
        pulse(2'b01);
        step("p0_nsg", 0,  7, L_NSG, 0, 0);
        step("p0_nsy", 1, 12, L_NSY, 0, 0);
        step("p0_ar1", 2,  8, L_AR,  0, 0);
        step("p0_ewg", 3, 24, L_EWG, 8, 0);
        step("p0_ewy", 4, 12, L_EWY, 0, 0);
        step("p0_ar2", 5,  8, L_AR,  0, 0);
        step("p0_nsg2", 0, 24, L_NSG, 0, 0);

        // EW-road crossing press during NS_Y: EW_G truncated, walk[1] at NS_G
        pulse(2'b10);
        step("p1_nsy", 1, 11, L_NSY, 0, 0);
        step("p1_ar1", 2,  8, L_AR,  0, 0);
        step("p1_ewg", 3,  8, L_EWG, 0, 0);
        step("p1_ewy", 4, 12, L_EWY, 0, 0);
        step("p1_ar2", 5,  8, L_AR,  0, 0);
        step("p1_nsg", 0, 24, L_NSG, 0, 8);

        // Reset mid EW_Y with both requests pending
        pulse(2'b10);
        step("rs_nsy", 1, 11, L_NSY, 0, 0);
        step("rs_ar1", 2,  8, L_AR,  0, 0);
        step("rs_ewg", 3,  8, L_EWG, 0, 0);
        pulse(2'b01);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rs_leds",  int'(LEDS),  int'(L_NSG));
        chk("rs_walk",  int'(walk),  0);
        chk("rs_phase", int'(phase), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rs_nsg2", 0, 24, L_NSG, 0, 0);
        step("rs_nsy2", 1, 12, L_NSY, 0, 0);
        step("rs_ar12", 2,  8, L_AR,  0, 0);
        step("rs_ewg2", 3, 24, L_EWG, 0, 0);
        step("rs_ewy2", 4, 12, L_EWY, 0, 0);
        step("rs_ar22", 5,  8, L_AR,  0, 0);

        // Emergency request toward EW at NS_G tick 0
        emerg_dir = 1'b1;
        emerg_req = 1'b1;
`ifdef EMERG_PREEMPT_EN
        step("em_nsg", 0,  4, L_NSG, 0, 0);
        step("em_nsy", 1, 12, L_NSY, 0, 0);
        step("em_ar1", 2,  8, L_AR,  0, 0);
        repeat (80) @(negedge clk);
        chk("em_hold_phase", int'(phase), 3);
        chk("em_hold_walk",  int'(walk),  0);
        emerg_req = 1'b0;
        step("em_ewg", 3, 24, L_EWG, 0, 0);
`else
        step("em_nsg", 0, 24, L_NSG, 0, 0);
        step("em_nsy", 1, 12, L_NSY, 0, 0);
        step("em_ar1", 2,  8, L_AR,  0, 0);
        step("em_ewg", 3, 24, L_EWG, 0, 0);
        emerg_req = 1'b0;
`endif
        step("em_ewy", 4, 12, L_EWY, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick (>=2).
REQ-002 Parameter GREEN_NS, default 10, NS green length in ticks.
REQ-003 Parameter GREEN_EW, default 10, EW green length in ticks.
REQ-004 Parameter GREEN_MIN, default 4, minimum green in ticks before pedestrian truncation (1..min(GREEN_NS,GREEN_EW)).
REQ-005 Parameter YELLOW, default 3; ALLRED, default 2; WALK, default 5 (all in ticks, 1..63, WALK<=GREEN_MIN).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 ped_req  input  2  pedestrian buttons; bit0 cross NS road, bit1 cross EW road; level, any width.
REQ-009 emerg_req  input  1  emergency preemption request, level.
REQ-010 emerg_dir  input  1  preemption target: 0 NS green, 1 EW green.
REQ-011 LEDS  output  6  {NS_G,NS_Y,NS_R,EW_G,EW_Y,EW_R}, registered.
REQ-012 walk  output  2  walk lamps, same bit mapping as ped_req, registered.
REQ-013 phase  output  3  current state encoding.

Function
REQ-014 Tick: prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1; wraps to 0.
REQ-015 States in order: NS_G(0) -> NS_Y(1) -> AR1(2) -> EW_G(3) -> EW_Y(4) -> AR2(5) -> NS_G; encodings 6,7 return to NS_G next cycle.
REQ-016 LEDS per state: NS_G 100001, NS_Y 010001, AR1/AR2 001001, EW_G 001100, EW_Y 001010; illegal 001001.
REQ-017 Phase timer tcnt (6 bit) counts ticks in state, cleared on every state change; state of length N exits on tick with tcnt==N-1.
REQ-018 Ped latch: ped_req[i] rising to 1 sets pend[i]; pend[i] clears on entry to serving green (bit0 EW_G, bit1 NS_G); a press while walk[i]=1 is ignored.
REQ-019 Truncation: in NS_G with pend[0]=1 and tcnt>=GREEN_MIN-1, exit to NS_Y on next tick; EW_G with pend[1] symmetric.
REQ-020 Walk: walk[i] asserts on the cycle the serving green is entered if pend[i] was set, held exactly WALK ticks, then deasserts; never asserted outside serving green.
REQ-021 Yellow and all-red are never shortened or extended by any input.
REQ-022 Simultaneous press and pend clear in the same cycle: clear wins, press dropped.
REQ-023 Outputs change only on the clk edge following the state transition (one-cycle registered latency).

Reset
REQ-024 rst_n=0 asynchronously forces state NS_G, tcnt 0, prescaler 0, pend 00, LEDS 100001, walk 00, phase 000.
REQ-025 Reset mid-phase discards all pending requests; first tick after release is TICK_DIV cycles later.

Configuration
REQ-026 Macro EMERG_PREEMPT_EN: defined -> emergency logic present; undefined -> emerg_req/emerg_dir ignored, no related flops.
REQ-027 With macro: emerg_req=1 in the green opposing emerg_dir exits to yellow on next tick regardless of GREEN_MIN.
REQ-028 With macro: in target green with emerg_req=1, tcnt frozen and state held; walk forced 00 while held; normal timing resumes on release.
REQ-029 With macro: emerg_req in yellow/all-red has no effect until target green or opposing green reached.

Structure
REQ-030 Package traffic_pkg holds state encodings and the six LEDS constants.
REQ-031 Sub-module tick_gen (parameter TICK_DIV, outputs tick) implements REQ-014.

Verification (TICK_DIV=4, GREEN_NS=GREEN_EW=6, GREEN_MIN=2, YELLOW=3, ALLRED=2, WALK=2)
REQ-032 Free run, no inputs -> NS_G 24 cycles, NS_Y 12, AR1 8, EW_G 24, EW_Y 12, AR2 8; LEDS patterns per REQ-016.
REQ-033 ped_req[0] pulsed 1 cycle at tick 0 of NS_G -> NS_Y entered after tick 2; walk[0]=1 for 8 cycles from EW_G entry; pend[0] cleared.
REQ-034 ped_req[1] pressed during NS_Y -> NS_Y/AR1 unchanged; EW_G truncated at tick 2; walk[1] at NS_G entry.
REQ-035 rst_n low for 1 cycle mid EW_Y with pend=11 -> LEDS 100001, walk 00 immediately; NS_G full 6 ticks.
REQ-036 With EMERG_PREEMPT_EN, emerg_req=1, emerg_dir=1 at NS_G tick 0 -> NS_Y after next tick; EW_G held 20 ticks while high; released -> EW_G ends 6 ticks later.
REQ-037 Without macro, same stimulus as REQ-036 -> timing identical to REQ-032.
